// File: rtl/perm16_pkg.sv
// Shared encodings and constants for the 16-bit permutation sequencer.
package perm16_pkg;

  localparam int W = 16;

  localparam logic [1:0] OP_PASS = 2'd0;
  localparam logic [1:0] OP_REV  = 2'd1;
  localparam logic [1:0] OP_ROL  = 2'd2;
  localparam logic [1:0] OP_ROR  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of RUN steps an operation needs: one for PASS/REV, amount for rotates.
  function automatic logic [3:0] step_count(input logic [1:0] op, input logic [3:0] amount);
    return ((op == OP_PASS) || (op == OP_REV)) ? 4'd1 : amount;
  endfunction

endpackage

// File: rtl/bit_rev16.sv
// Purely combinational full bit reversal: bit i of din lands on bit W-1-i of dout.
module bit_rev16
  import perm16_pkg::*;
(
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  // Mirror every bit position.
  always_comb begin
    // NOTE: assign a default before the loop so every path drives dout and no latch is inferred.
    dout = '0;
    for (int i = 0; i < W; i++) begin
      dout[W-1-i] = din[i];
    end
  end

endmodule

// File: rtl/perm16_seq.sv
// Start/busy/done sequencer around a 16-bit work register: PASS and REV take one
// step, ROL/ROR rotate one bit per cycle for 'amount' cycles.
module perm16_seq
  import perm16_pkg::*;
#(
  parameter int           UUID = 0,
  parameter logic [127:0] NAME = ""
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [3:0]   amount,
  input  logic [W-1:0] din,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] dout
);

  state_t         state;
  state_t         state_next;
  logic [1:0]     op_q;
  logic [3:0]     count;
  logic [3:0]     start_count;
  logic [W-1:0]   work;
  logic [W-1:0]   rev_work;
  logic [W-1:0]   step_value;

  // Instance identifiers carry no function; fold them into a sink so they are referenced.
  logic unused_params;
  assign unused_params = ^{UUID, NAME};

  bit_rev16 u_rev (
    .din  (work),
    .dout (rev_work)
  );

  assign start_count = step_count(op, amount);

  // Value the work register takes after one RUN step of the latched operation.
  always_comb begin
    step_value = work;
    case (op_q)
      OP_REV:  step_value = rev_work;
      OP_ROL:  step_value = {work[W-2:0], work[W-1]};
      OP_ROR:  step_value = {work[0], work[W-1:1]};
      default: step_value = work;
    endcase
  end

  // Next-state decode; start is only honoured in IDLE, a zero count skips RUN.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = (start_count != 4'd0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (count == 4'd1) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State, counter, latched op and work register; reset aborts any operation.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) begin
      state <= ST_IDLE;
      op_q  <= OP_PASS;
      count <= 4'd0;
      work  <= '0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q  <= op;
            count <= start_count;
            work  <= din;
          end
        end
        ST_RUN: begin
          work  <= step_value;
          count <= count - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);
  assign dout = work;

endmodule

// File: tb/tb_perm16_seq.sv
// Self-checking bench for perm16_seq: directed test-plan cases plus random
// operations compared against an arithmetic reference model.
module tb_perm16_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [3:0]  amount;
  logic [15:0] din;
  logic        busy;
  logic        done;
  logic [15:0] dout;

  int n_checks = 0;
  int n_errors = 0;

  perm16_seq #(.UUID(7), .NAME("perm_tb")) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .amount (amount),
    .din    (din),
    .busy   (busy),
    .done   (done),
    .dout   (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: rotations as plain shift arithmetic, reversal bit by bit.
  function automatic logic [15:0] m_rol(input logic [15:0] x, input int n);
    int v;
    v = ((int'(x) << n) | (int'(x) >> (16 - n))) & 32'hFFFF;
    return v[15:0];
  endfunction

  function automatic logic [15:0] m_rev(input logic [15:0] x);
    logic [15:0] r = '0;
    for (int i = 0; i < 16; i++) r[15 - i] = x[i];
    return r;
  endfunction

  function automatic logic [15:0] m_result(input logic [1:0] o, input int a, input logic [15:0] x);
    case (o)
      2'd0:    return x;
      2'd1:    return m_rev(x);
      2'd2:    return m_rol(x, a);
      default: return m_rol(x, (16 - a) % 16);
    endcase
  endfunction

  function automatic int m_steps(input logic [1:0] o, input int a);
    return (o < 2'd2) ? 1 : a;
  endfunction

  // Called at a negedge (cycle t): issue the op, then follow it to t+k+2.
  task automatic do_op(input logic [1:0] o, input logic [3:0] a, input logic [15:0] d);
    int          k;
    logic [15:0] exp;
    k      = m_steps(o, int'(a));
    exp    = m_result(o, int'(a), d);
    start  = 1'b1;
    op     = o;
    amount = a;
    din    = d;
    @(negedge clk);
    start  = 1'b0;
    op     = 2'($urandom);
    amount = 4'($urandom);
    din    = 16'($urandom);
    for (int c = 1; c <= k + 1; c++) begin
      if (c > 1) @(negedge clk);
      check("busy_run", 16'(busy), 16'd1);
      check("done_time", 16'(done), 16'(c == k + 1));
      if (c == k + 1) check("dout_done", dout, exp);
    end
    @(negedge clk);
    check("busy_idle", 16'(busy), 16'd0);
    check("done_idle", 16'(done), 16'd0);
    check("dout_hold", dout, exp);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    op     = 2'd0;
    amount = 4'd0;
    din    = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_dout", dout, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    // Test-plan directed cases.
    do_op(2'd1, 4'd9, 16'h0001);
    do_op(2'd2, 4'd1, 16'h8001);
    do_op(2'd3, 4'd4, 16'h0001);
    do_op(2'd0, 4'd3, 16'hBEEF);
    do_op(2'd2, 4'd0, 16'h1234);
    do_op(2'd3, 4'd0, 16'hC3C3);
    do_op(2'd2, 4'd15, 16'h1357);
    do_op(2'd3, 4'd15, 16'h1357);

    // Long rotate aborted by reset, with an ignored start in the middle.
    start  = 1'b1;
    op     = 2'd2;
    amount = 4'd15;
    din    = 16'hA5A5;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      din   = 16'h0000;
      check("abort_busy", 16'(busy), 16'd1);
      check("abort_done", 16'(done), 16'd0);
      check("abort_dout", dout, m_rol(16'hA5A5, c - 1));
      if (c == 3) begin
        start = 1'b1;
        op    = 2'd0;
        din   = 16'hFFFF;
      end
      if (c == 6) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    check("abort_rst_busy", 16'(busy), 16'd0);
    check("abort_rst_done", 16'(done), 16'd0);
    check("abort_rst_dout", dout, 16'h0000);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("abort_no_done", 16'(done), 16'd0);
      check("abort_no_busy", 16'(busy), 16'd0);
    end

    // Reset wins over a simultaneous start; the retry one cycle later is accepted.
    rst    = 1'b1;
    start  = 1'b1;
    op     = 2'd1;
    din    = 16'h00FF;
    @(negedge clk);
    rst    = 1'b0;
    start  = 1'b0;
    check("rst_start_busy", 16'(busy), 16'd0);
    check("rst_start_dout", dout, 16'h0000);
    do_op(2'd1, 4'd0, 16'h00FF);

    // Random operations, some back to back, some after idle gaps with noise on inputs.
    for (int n = 0; n < 80; n++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        op     = 2'($urandom);
        amount = 4'($urandom);
        din    = 16'($urandom);
        @(negedge clk);
        check("gap_busy", 16'(busy), 16'd0);
      end
      do_op(2'($urandom), 4'($urandom), 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
